// File: rtl/l1_sched_pkg.sv
// Shared types, defaults and helpers for the L1 cacheline request scheduler.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package l1_sched_pkg;

    localparam int NSTREAMS_DEF = 8;
    localparam int NCL_DEF      = 16;
    localparam int MAX_OUT_DEF  = 16;

    // Widest stream vector the one-hot helper can decode.
    localparam int ONEHOT_W     = 64;

    // Field widths of the request record; instances narrow them on output.
    localparam int REQ_SID_W    = 8;
    localparam int REQ_CLID_W   = 16;

    typedef struct packed {
        logic [REQ_SID_W-1:0]  sid;
        logic [REQ_CLID_W-1:0] clid;
    } req_t;

    // Decode an index into a one-hot vector.
    function automatic logic [ONEHOT_W-1:0] onehot(input int idx);
        logic [ONEHOT_W-1:0] one;
        one = {{(ONEHOT_W-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

    // Increment with wrap to zero at lim-1; lim need not be a power of two.
    function automatic int wrap_inc(input int v, input int lim);
        return (v >= lim - 1) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/base_rr_arb.sv
// Round-robin arbiter: one-hot grant to first requester at/after the rr pointer.
// Latency: combinational grant; pointer advances past the winner on the next edge.
// Backpressure: en_i low suppresses all grants and freezes the pointer.
module base_rr_arb
    import l1_sched_pkg::*;
#(
    parameter int n         = 8,
    parameter int idx_width = $clog2(n)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [n-1:0]         req_i,
    input  logic                 en_i,
    output logic [n-1:0]         gnt_o,
    output logic [idx_width-1:0] idx_o,
    output logic                 vld_o
);

    logic [idx_width-1:0] ptr_q;
    logic [idx_width-1:0] ptr_d;
    logic                 found;
    int                   cand;

    // Search upward from the pointer, wrapping at n, and take the first requester.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = 0;
        if (en_i) begin
            for (int i = 0; i < n; i++) begin
                cand = int'(ptr_q) + i;
                if (cand >= n) begin
                    cand = cand - n;
                end
                if (!found && req_i[idx_width'(cand)]) begin
                    found = 1'b1;
                    idx_o = idx_width'(cand);
                    gnt_o[idx_width'(cand)] = 1'b1;
                end
            end
        end
        vld_o = found;
    end

    // Next search starts just past the winner; pointer holds when nothing is granted.
    always_comb begin
        ptr_d = ptr_q;
        if (found) begin
            ptr_d = idx_width'(wrap_inc(int'(idx_o), n));
        end
    end

    // Pointer register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/l1_clreq_sched.sv
// Schedules per-stream L1 line requests onto one L2 channel, routes L2 responses back.
// Latency: grant in cycle N, o_req_v in N+1; response routing is combinational.
// Backpressure: o_req_r low holds the output stage and blocks grants; credit cap max_out.
module l1_clreq_sched
    import l1_sched_pkg::*;
#(
    parameter int nstreams   = NSTREAMS_DEF,
    parameter int ncl        = NCL_DEF,
    parameter int max_out    = MAX_OUT_DEF,
    parameter int sid_width  = $clog2(nstreams),
    parameter int clid_width = $clog2(ncl),
    parameter int out_width  = $clog2(max_out + 1)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [nstreams-1:0]            i_clreq_v,
    output logic [nstreams-1:0]            i_clreq_r,
    input  logic [nstreams-1:0]            i_rst_v,
    input  logic [nstreams*clid_width-1:0] i_rst_clid,
    output logic                           o_req_v,
    input  logic                           o_req_r,
    output logic [sid_width-1:0]           o_req_sid,
    output logic [clid_width-1:0]          o_req_clid,
    input  logic                           i_rsp_v,
    output logic                           i_rsp_r,
    input  logic [sid_width-1:0]           i_rsp_sid,
    output logic [nstreams-1:0]            o_clrsp_v,
    input  logic [nstreams-1:0]            o_clrsp_r,
    output logic [out_width-1:0]           o_out_cnt,
    output logic                           o_idle
);

    logic [nstreams-1:0]   elig;
    logic                  can_issue;
    logic [nstreams-1:0]   gnt;
    logic [sid_width-1:0]  gnt_idx;
    logic                  gnt_vld;
    logic                  sid_ok;
    logic                  rsp_fire;

    logic                  req_v_q;
    logic                  req_v_d;
    req_t                  req_q;
    req_t                  req_d;
    logic [clid_width-1:0] wptr_q [nstreams];
    logic [clid_width-1:0] wptr_d [nstreams];
    logic [out_width-1:0]  cnt_q;
    logic [out_width-1:0]  cnt_d;
    logic                  unused_req_hi;

    // A stream being reset this cycle sits out arbitration.
    assign elig      = i_clreq_v & ~i_rst_v;
    // Credit is reserved at grant, so the cap is checked against the grant itself.
    assign can_issue = (cnt_q < out_width'(max_out)) && (!req_v_q || o_req_r);

    base_rr_arb #(
        .n         (nstreams),
        .idx_width (sid_width)
    ) u_arb (
        .clk_i (clk),
        .rst_i (reset),
        .req_i (elig),
        .en_i  (can_issue),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .vld_o (gnt_vld)
    );

    assign i_clreq_r = gnt;

    // Response routing; an out-of-range sid is swallowed so the channel never wedges.
    assign sid_ok    = (int'(i_rsp_sid) < nstreams);
    assign i_rsp_r   = sid_ok ? o_clrsp_r[i_rsp_sid] : 1'b1;
    assign o_clrsp_v = (i_rsp_v && sid_ok) ? nstreams'(onehot(int'(i_rsp_sid))) : '0;
    assign rsp_fire  = i_rsp_v && i_rsp_r;

    // Output stage: load on grant, drop valid once taken with nothing new behind it.
    always_comb begin
        req_v_d = req_v_q;
        req_d   = req_q;
        if (gnt_vld) begin
            req_v_d    = 1'b1;
            req_d.sid  = REQ_SID_W'(gnt_idx);
            req_d.clid = REQ_CLID_W'(wptr_q[gnt_idx]);
        end else if (o_req_r) begin
            req_v_d = 1'b0;
        end
    end

    // Per-stream slot pointers: reload on stream reset, wrap-advance on grant.
    always_comb begin
        for (int k = 0; k < nstreams; k++) begin
            wptr_d[k] = wptr_q[k];
            if (i_rst_v[k]) begin
                wptr_d[k] = i_rst_clid[k*clid_width +: clid_width];
            end else if (gnt[k]) begin
                wptr_d[k] = clid_width'(wrap_inc(int'(wptr_q[k]), ncl));
            end
        end
    end

    // Outstanding credits; a response with nothing outstanding leaves the count at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (gnt_vld && !rsp_fire) begin
            cnt_d = cnt_q + out_width'(1);
        end else if (!gnt_vld && rsp_fire && (cnt_q != '0)) begin
            cnt_d = cnt_q - out_width'(1);
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_v_q <= 1'b0;
            req_q   <= '0;
            cnt_q   <= '0;
            for (int k = 0; k < nstreams; k++) begin
                wptr_q[k] <= '0;
            end
        end else begin
            req_v_q <= req_v_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
            for (int k = 0; k < nstreams; k++) begin
                wptr_q[k] <= wptr_d[k];
            end
        end
    end

    assign o_req_v    = req_v_q;
    assign o_req_sid  = sid_width'(req_q.sid);
    assign o_req_clid = clid_width'(req_q.clid);
    assign o_out_cnt  = cnt_q;
    assign o_idle     = (cnt_q == '0) && !req_v_q;

    // Upper record bits stay zero for narrow instances.
    assign unused_req_hi = |{req_q.sid >> sid_width, req_q.clid >> clid_width};

    a_rsp_underflow: assert property (@(posedge clk) disable iff (reset)
        (i_rsp_v && i_rsp_r) |-> (cnt_q != '0));

    a_rsp_sid_range: assert property (@(posedge clk) disable iff (reset)
        i_rsp_v |-> sid_ok);

endmodule

// File: tb/tb_l1_clreq_sched.sv
module tb_l1_clreq_sched;

    localparam int NS   = 8;
    localparam int NCL  = 16;
    localparam int MAXO = 16;
    localparam int SW   = 3;
    localparam int CW   = 4;
    localparam int OW   = 5;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NS-1:0]     clreq_v = '0;
    logic [NS-1:0]     clreq_r;
    logic [NS-1:0]     rst_v = '0;
    logic [NS*CW-1:0]  rst_clid = '0;
    logic              req_v;
    logic              req_r = 1'b0;
    logic [SW-1:0]     req_sid;
    logic [CW-1:0]     req_clid;
    logic              rsp_v = 1'b0;
    logic              rsp_r;
    logic [SW-1:0]     rsp_sid = '0;
    logic [NS-1:0]     clrsp_v;
    logic [NS-1:0]     clrsp_r = '1;
    logic [OW-1:0]     out_cnt;
    logic              idle;

    // Reference model state
    int m_rr = 0;
    int m_wptr[NS];
    int m_cnt = 0;
    bit m_v = 1'b0;
    int m_sid = 0;
    int m_clid = 0;
    int l2q[$];

    int checks = 0;
    int errors = 0;
    int pat[3] = '{0, 3, 5};

    always #5 clk = ~clk;

    l1_clreq_sched #(
        .nstreams   (NS),
        .ncl        (NCL),
        .max_out    (MAXO),
        .sid_width  (SW),
        .clid_width (CW),
        .out_width  (OW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .i_clreq_v  (clreq_v),
        .i_clreq_r  (clreq_r),
        .i_rst_v    (rst_v),
        .i_rst_clid (rst_clid),
        .o_req_v    (req_v),
        .o_req_r    (req_r),
        .o_req_sid  (req_sid),
        .o_req_clid (req_clid),
        .i_rsp_v    (rsp_v),
        .i_rsp_r    (rsp_r),
        .i_rsp_sid  (rsp_sid),
        .o_clrsp_v  (clrsp_v),
        .o_clrsp_r  (clrsp_r),
        .o_out_cnt  (out_cnt),
        .o_idle     (idle)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, expv, $time);
        end
    endtask

    function automatic bit bit_at(input logic [NS-1:0] v, input int k);
        logic [NS-1:0] t;
        t = v >> k;
        return t[0];
    endfunction

    task automatic model_reset();
        m_rr = 0;
        m_cnt = 0;
        m_v = 1'b0;
        m_sid = 0;
        m_clid = 0;
        for (int k = 0; k < NS; k++) m_wptr[k] = 0;
        l2q.delete();
    endtask

    // L2 side: answers the oldest accepted request with probability pct.
    task automatic auto_rsp(input int pct);
        if (l2q.size() > 0 && $urandom_range(99) < pct) begin
            rsp_v = 1'b1;
            rsp_sid = SW'(l2q[0]);
        end else begin
            rsp_v = 1'b0;
            rsp_sid = '0;
        end
    endtask

    // Called at a negedge with inputs set; checks combinational outputs, clocks, checks state.
    task automatic run_cycle();
        int gk;
        int k;
        bit en;
        bit rsp_fire;
        logic [NS-1:0] exp_gnt;
        logic [NS-1:0] exp_clrsp;
        logic exp_rspr;
        en = (m_cnt < MAXO) && (!m_v || req_r);
        gk = -1;
        if (en) begin
            for (int i = 0; i < NS; i++) begin
                k = (m_rr + i) % NS;
                if (gk < 0 && bit_at(clreq_v, k) && !bit_at(rst_v, k)) gk = k;
            end
        end
        exp_gnt = (gk >= 0) ? (NS'(1) << gk) : '0;
        exp_clrsp = rsp_v ? (NS'(1) << rsp_sid) : '0;
        exp_rspr = bit_at(clrsp_r, int'(rsp_sid));
        rsp_fire = rsp_v && exp_rspr;
        #1;
        check("clreq_r", 64'(clreq_r), 64'(exp_gnt));
        check("clrsp_v", 64'(clrsp_v), 64'(exp_clrsp));
        check("rsp_r", 64'(rsp_r), 64'(exp_rspr));
        @(posedge clk);
        if (m_v && req_r) l2q.push_back(m_sid);
        if (rsp_fire && l2q.size() > 0) void'(l2q.pop_front());
        if (gk >= 0) begin
            m_rr = (gk + 1) % NS;
            m_v = 1'b1;
            m_sid = gk;
            m_clid = m_wptr[gk];
            m_wptr[gk] = (m_wptr[gk] + 1) % NCL;
        end else if (req_r) begin
            m_v = 1'b0;
        end
        for (int j = 0; j < NS; j++) begin
            if (bit_at(rst_v, j)) m_wptr[j] = int'(CW'(rst_clid >> (j * CW)));
        end
        m_cnt = m_cnt + ((gk >= 0) ? 1 : 0) - (rsp_fire ? 1 : 0);
        if (m_cnt < 0) m_cnt = 0;
        #1;
        check("req_v", 64'(req_v), 64'(m_v));
        if (m_v) begin
            check("req_sid", 64'(req_sid), 64'(m_sid));
            check("req_clid", 64'(req_clid), 64'(m_clid));
        end
        check("out_cnt", 64'(out_cnt), 64'(m_cnt));
        check("idle", 64'(idle), 64'(m_cnt == 0 && !m_v));
        @(negedge clk);
    endtask

    task automatic drain();
        clreq_v = '0;
        rst_v = '0;
        req_r = 1'b1;
        clrsp_r = '1;
        for (int c = 0; c < 200; c++) begin
            if (m_cnt == 0 && !m_v) break;
            auto_rsp(100);
            run_cycle();
        end
        rsp_v = 1'b0;
        rsp_sid = '0;
        #1;
        check("drain_idle", 64'(idle), 64'(1));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_req_v", 64'(req_v), 64'(0));
        check("rst_sid", 64'(req_sid), 64'(0));
        check("rst_clid", 64'(req_clid), 64'(0));
        check("rst_cnt", 64'(out_cnt), 64'(0));
        check("rst_idle", 64'(idle), 64'(1));
        reset = 1'b0;

        // Streams 0,3,5 continuously, no responses: fills the credit pool.
        clreq_v = NS'(8'b0010_1001);
        req_r = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            run_cycle();
            if (i <= 16) check("rr_sid", 64'(req_sid), 64'(pat[(i - 1) % 3]));
        end
        check("cnt_full", 64'(out_cnt), 64'(16));
        check("full_nogrant", 64'(clreq_r), 64'(0));
        drain();

        // Stream 2 alone: slot pointer wraps at NCL.
        clreq_v = NS'(1) << 2;
        req_r = 1'b1;
        for (int i = 1; i <= 18; i++) begin
            auto_rsp(100);
            run_cycle();
            check("wrap_clid", 64'(req_clid), 64'((i - 1) % NCL));
        end
        drain();

        // Stall: hold stream 1 in the output stage with others waiting.
        clreq_v = NS'(1) << 1;
        req_r = 1'b0;
        run_cycle();
        clreq_v = NS'(8'b0101_0010);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall_nogrant", 64'(clreq_r), 64'(0));
            run_cycle();
            check("stall_v", 64'(req_v), 64'(1));
            check("stall_sid", 64'(req_sid), 64'(1));
        end
        req_r = 1'b1;
        #1;
        check("release_gnt", 64'(clreq_r), 64'(NS'(1) << 4));
        run_cycle();
        drain();

        // Credit exhaustion with stream 4 only.
        clreq_v = NS'(1) << 4;
        req_r = 1'b1;
        for (int c = 0; c < 40 && m_cnt < MAXO; c++) run_cycle();
        check("credit_fill", 64'(out_cnt), 64'(16));
        clreq_v = NS'(8'b0001_0011);
        rsp_v = 1'b1;
        rsp_sid = SW'(l2q[0]);
        #1;
        check("credit_block", 64'(clreq_r), 64'(0));
        run_cycle();
        check("credit_rsp", 64'(out_cnt), 64'(15));
        rsp_v = 1'b0;
        run_cycle();
        check("credit_regrant", 64'(out_cnt), 64'(16));
        clreq_v = '0;
        for (int c = 0; c < 40 && m_cnt > 7; c++) begin
            auto_rsp(100);
            run_cycle();
        end
        check("credit_seven", 64'(out_cnt), 64'(7));
        clreq_v = NS'(1) << 4;
        auto_rsp(100);
        run_cycle();
        check("grant_and_rsp", 64'(out_cnt), 64'(7));
        drain();

        // Response routing with stream 6 holding back.
        clreq_v = NS'(1) << 6;
        run_cycle();
        clreq_v = '0;
        run_cycle();
        rsp_v = 1'b1;
        rsp_sid = SW'(6);
        clrsp_r = ~(NS'(1) << 6);
        for (int i = 0; i < 2; i++) begin
            #1;
            check("route_v", 64'(clrsp_v), 64'(8'h40));
            check("route_hold", 64'(rsp_r), 64'(0));
            run_cycle();
            check("route_cnt_hold", 64'(out_cnt), 64'(1));
        end
        clrsp_r = '1;
        #1;
        check("route_rdy", 64'(rsp_r), 64'(1));
        run_cycle();
        check("route_cnt_dec", 64'(out_cnt), 64'(0));
        rsp_v = 1'b0;
        rsp_sid = '0;

        // Stream reset reloads the slot pointer and masks the stream for that cycle.
        clreq_v = NS'(1) << 3;
        rst_v = NS'(1) << 3;
        rst_clid[3*CW +: CW] = CW'(9);
        #1;
        check("srst_mask", 64'(clreq_r), 64'(0));
        run_cycle();
        rst_v = '0;
        run_cycle();
        check("srst_sid", 64'(req_sid), 64'(3));
        check("srst_clid9", 64'(req_clid), 64'(9));
        run_cycle();
        check("srst_clid10", 64'(req_clid), 64'(10));
        drain();

        // Randomized traffic.
        for (int c = 0; c < 500; c++) begin
            clreq_v = NS'($urandom);
            rst_v = ($urandom_range(9) == 0) ? (NS'(1) << $urandom_range(NS - 1)) : '0;
            for (int k = 0; k < NS; k++) rst_clid[k*CW +: CW] = CW'($urandom_range(NCL - 1));
            req_r = ($urandom_range(3) != 0);
            clrsp_r = NS'($urandom) | NS'($urandom);
            auto_rsp(50);
            run_cycle();
        end
        rst_v = '0;
        drain();

        // Async reset in the middle of a burst.
        clreq_v = '1;
        req_r = 1'b1;
        repeat (4) run_cycle();
        #2;
        reset = 1'b1;
        #1;
        check("arst_req_v", 64'(req_v), 64'(0));
        check("arst_cnt", 64'(out_cnt), 64'(0));
        check("arst_idle", 64'(idle), 64'(1));
        model_reset();
        clreq_v = '0;
        @(negedge clk);
        reset = 1'b0;
        clreq_v = '1;
        run_cycle();
        check("post_rst_sid", 64'(req_sid), 64'(0));
        run_cycle();
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/l1_clreq_sched.md
Name: l1_clreq_sched

Overview:
Schedules cacheline fetch requests from nstreams L1 stream pointers onto the single L2 request channel and routes L2 line-delivery responses back to the owning stream.
- Round-robin arbitration across streams.
- Tags each request with stream id and destination L1 line slot (per-stream wrapping write pointer).
- Caps total in-flight L2 requests with a credit counter.
- Sits between the per-stream L1 pointer blocks (their clreq/clrsp handshakes) and the L2 stream fetch logic.

Parameters:
nstreams, 8, number of L1 streams sharing L2
ncl, 16, cachelines per stream buffer (need not be a power of 2)
max_out, 16, maximum outstanding L2 requests across all streams
sid_width, $clog2(nstreams), stream id width
clid_width, $clog2(ncl), line slot id width
out_width, $clog2(max_out+1), outstanding counter width

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
i_clreq_v  in  nstreams  per-stream line request valid
i_clreq_r  out  nstreams  per-stream request accepted (one-hot grant)
i_rst_v  in  nstreams  per-stream functional reset pulse (stream reset handshake act)
i_rst_clid  in  nstreams*clid_width  per-stream starting line slot; slice k belongs to stream k
o_req_v  out  1  L2 request valid
o_req_r  in  1  L2 request ready
o_req_sid  out  sid_width  requesting stream
o_req_clid  out  clid_width  destination line slot in that stream
i_rsp_v  in  1  L2 line delivered
i_rsp_r  out  1  response ready
i_rsp_sid  in  sid_width  stream the line belongs to
o_clrsp_v  out  nstreams  per-stream response valid
o_clrsp_r  in  nstreams  per-stream response ready
o_out_cnt  out  out_width  current outstanding count
o_idle  out  1  no outstanding requests and output stage empty

Behaviour:
- Reset (async, active-high): o_req_v=0, o_req_sid=0, o_req_clid=0, rr pointer=0, all write pointers=0, outstanding count=0, o_idle=1. Combinational outputs i_clreq_r, o_clrsp_v and i_rsp_r follow their equations.
- Eligible[k] = i_clreq_v[k] & ~i_rst_v[k].
- Grant enable = (count < max_out) & (~o_req_v | o_req_r).
- Round-robin: search from rr pointer upward, wrapping at nstreams. Grant the first eligible stream k; i_clreq_r[k]=1, all other bits 0. At most one grant per cycle.
- On grant to k:
  - rr pointer <= (k+1) mod nstreams.
  - Output register <= {v=1, sid=k, clid=wptr[k]}.
  - wptr[k] <= (wptr[k]==ncl-1) ? 0 : wptr[k]+1.
- With no grant, rr pointer holds.
- Latency: grant in cycle N, o_req_v visible in cycle N+1. Output register holds sid/clid stable while o_req_v & ~o_req_r. It clears when o_req_r is high and no new grant occurs. Back-to-back grants give one request per cycle when o_req_r stays high.
- Outstanding count: +1 on grant (credit reserved at grant), -1 on i_rsp_v & i_rsp_r.
  - Simultaneous grant and response: count unchanged.
  - No grant while count==max_out.
  - Response with count==0 is a protocol error: count saturates at 0, and a simulation-only assertion fires.
- Response routing (combinational, 0 latency): o_clrsp_v = i_rsp_v ? onehot(i_rsp_sid) : 0. i_rsp_r = o_clrsp_r[i_rsp_sid]. i_rsp_sid >= nstreams is an assertion error; that response is dropped with i_rsp_r=1.
- Stream reset: i_rst_v[k] loads wptr[k] <= i_rst_clid[k] and masks stream k from arbitration that cycle. Other streams are unaffected. A request of stream k already in the output register is still issued unchanged. The outstanding count is not modified by stream resets, because the stream only resets when it has no outstanding requests.
- o_idle = (count==0) & ~o_req_v.
- o_out_cnt = count (registered).

Decomposition:
- Package l1_sched_pkg:
  - Functions: onehot decode, wrap-increment.
  - Default parameter constants.
  - Typedef req_t {sid, clid}, used for the output register.
- Sub-module base_rr_arb (nstreams-wide round-robin arbiter):
  - Inputs: request vector, enable.
  - Outputs: one-hot grant, encoded index.
  - Owns the rr pointer register.
- Everything else stays inline.

Test Plan:
- Streams 0,3,5 request continuously, o_req_r=1, no responses, max_out=16: sids issued 0,3,5,0,3,5,… one per cycle starting the cycle after the first grant. o_out_cnt reaches 16 after 16 grants, then all i_clreq_r=0.
- Stream 2 alone, 18 grants with responses returned: o_req_clid sequence 0..15,0,1 (wrap at ncl=16). Repeat with ncl=12: wraps after 11.
- Stall: grant stream 1, hold o_req_r=0 for 5 cycles with other streams requesting: o_req_v/sid/clid stable, no further i_clreq_r. On release, the next RR stream is granted the same cycle.
- Credit: count=16, same-cycle response for sid 4 and pending requests: no grant that cycle. Next cycle a grant occurs and count stays 16. With grant and response in the same cycle (count=7): count stays 7.
- Response routing: i_rsp_v=1, sid=6, o_clrsp_r[6]=0 for 2 cycles: o_clrsp_v=0x40, i_rsp_r=0, count unchanged. On o_clrsp_r[6]=1: i_rsp_r=1 and count decrements.
- Stream reset: i_rst_v[3]=1, i_rst_clid[3]=9 while stream 3 requests: stream 3 not granted that cycle. Its next grant carries clid 9, then 10. Async reset asserted mid-burst: o_req_v=0, o_out_cnt=0 and o_idle=1 immediately.
